// File: rtl/seq_bin2bcd_pkg.sv
// seq_bin2bcd_pkg
//   Shared definitions for the iterative binary-to-BCD converter:
//   FSM state encoding, BCD digit width, digit count and default input width.
package seq_bin2bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int BCD_W         = 4;
    localparam int DIGITS        = 3;
    localparam int DEFAULT_WIDTH = 8;

endpackage : seq_bin2bcd_pkg

// File: rtl/seq_bin2bcd_if.sv
// seq_bin2bcd_if
//   Request/result bundle between a requester (master) and the converter
//   (slave).
//
//   Handshake: the master raises start with bin valid. The request is taken
//   on a rising clock edge where the converter is idle (busy=0 and not in
//   its result cycle). Requests made while busy are dropped, not queued.
//   done pulses for exactly one cycle when ONES/TENS/HUNDREDS carry a new
//   result; the digits then hold until the next done. busy and done are
//   never high together.
//
//   Signals:
//     start     master->slave  conversion request
//     bin       master->slave  binary value, sampled with an accepted start
//     busy      slave->master  conversion in progress
//     done      slave->master  one-cycle result-valid pulse
//     ONES      slave->master  BCD units digit
//     TENS      slave->master  BCD tens digit
//     HUNDREDS  slave->master  BCD hundreds digit
//     state_dbg slave->master  current FSM state, for observation only
interface seq_bin2bcd_if
    import seq_bin2bcd_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] bin;
    logic             busy;
    logic             done;
    logic [BCD_W-1:0] ONES;
    logic [BCD_W-1:0] TENS;
    logic [BCD_W-1:0] HUNDREDS;
    state_t           state_dbg;

    modport master (
        output start, bin,
        input  busy, done, ONES, TENS, HUNDREDS, state_dbg
    );

    modport slave (
        input  start, bin,
        output busy, done, ONES, TENS, HUNDREDS, state_dbg
    );
endinterface : seq_bin2bcd_if

// File: rtl/seq_bin2bcd_dabble_digit.sv
// dabble_digit
//   Double-dabble correction for one BCD digit: adds 3 when the digit is 5
//   or more, so the following left shift carries into the next digit.
//   Ports:
//     din   4-bit scratch digit (0..9 in normal operation)
//     dout  corrected digit
//   Codes 10..15 cannot occur in a running conversion; they map to 0 so the
//   output stays a legal BCD code no matter what.
module dabble_digit
    import seq_bin2bcd_pkg::*;
(
    input  logic [BCD_W-1:0] din,
    output logic [BCD_W-1:0] dout
);

    always_comb begin
        dout = din;
        if (din >= 4'd10) begin
            dout = '0;
        end else if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule : dabble_digit

// File: rtl/seq_bin2bcd.sv
// seq_bin2bcd
//   Iterative (double-dabble) binary-to-BCD converter. Captures a WIDTH-bit
//   value on an accepted start, shifts one bit per clock for WIDTH cycles,
//   then publishes registered ONES/TENS/HUNDREDS together with a one-cycle
//   done pulse. The previous result stays on the outputs until then.
//   Ports:
//     CLOCK_50  system clock, rising edge
//     rst_n     asynchronous active-low reset
//     bus       slave side of seq_bin2bcd_if (start/bin in; busy/done/
//               digits/state_dbg out)
//   Timing: start accepted at edge N -> busy during cycles N+1..N+WIDTH ->
//   digits and done updated at edge N+WIDTH+1. One conversion every
//   WIDTH+2 cycles with start held high.
module seq_bin2bcd
    import seq_bin2bcd_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)(
    input  logic            CLOCK_50,
    input  logic            rst_n,
    seq_bin2bcd_if.slave    bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int DIG_W = DIGITS * BCD_W;
    localparam int CAT_W = DIG_W + WIDTH;

    state_t           state, state_n;
    logic [WIDTH-1:0] sr, sr_n;
    logic [DIG_W-1:0] dig, dig_n, dig_fix;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CAT_W-1:0] shifted;

    logic [BCD_W-1:0] ones_r, tens_r, hund_r;
    logic             done_r;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dabble
        dabble_digit u_dabble (
            .din  (dig[g*BCD_W +: BCD_W]),
            .dout (dig_fix[g*BCD_W +: BCD_W])
        );
    end

    // Correction happens before the shift; the shift register MSB moves
    // into units bit 0 as part of the same concatenated shift.
    assign shifted = {dig_fix, sr} << 1;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            sr     <= '0;
            dig    <= '0;
            cnt    <= '0;
            ones_r <= '0;
            tens_r <= '0;
            hund_r <= '0;
            done_r <= 1'b0;
        end else begin
            state  <= state_n;
            sr     <= sr_n;
            dig    <= dig_n;
            cnt    <= cnt_n;
            // The result cycle registers digits and done together, so both
            // appear on the same edge and done lands in the following IDLE.
            done_r <= (state == ST_DONE);
            if (state == ST_DONE) begin
                ones_r <= dig[0*BCD_W +: BCD_W];
                tens_r <= dig[1*BCD_W +: BCD_W];
                hund_r <= dig[2*BCD_W +: BCD_W];
            end
        end
    end

    always_comb begin
        state_n = state;
        sr_n    = sr;
        dig_n   = dig;
        cnt_n   = cnt;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    sr_n    = bus.bin;
                    dig_n   = '0;
                    cnt_n   = CNT_W'(WIDTH);
                    state_n = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                dig_n = shifted[CAT_W-1:WIDTH];
                sr_n  = shifted[WIDTH-1:0];
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign bus.busy      = (state == ST_SHIFT);
    assign bus.done      = done_r;
    assign bus.ONES      = ones_r;
    assign bus.TENS      = tens_r;
    assign bus.HUNDREDS  = hund_r;
    assign bus.state_dbg = state;

endmodule : seq_bin2bcd

// File: tb/tb_seq_bin2bcd.sv
module tb_seq_bin2bcd;
  import seq_bin2bcd_pkg::*;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   done_seen = 0;
  logic [11:0] exp_q[$];

  seq_bin2bcd_if #(.WIDTH(8)) bus ();

  seq_bin2bcd #(.WIDTH(8)) dut (
    .CLOCK_50 (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [11:0] ref_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  function automatic logic [11:0] digits();
    return {bus.HUNDREDS, bus.TENS, bus.ONES};
  endfunction

  // scoreboard: every done pulse is matched against the oldest expected result
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      logic [11:0] e;
      done_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done got=%03h expected=no done pulse", digits());
      end else begin
        e = exp_q.pop_front();
        if (digits() !== e) begin
          errors++;
          $display("FAIL sb_digits got=%03h expected=%03h", digits(), e);
        end
      end
      checks++;
      if (bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_with_done got=%b expected=0", bus.busy);
      end
    end
  end

  // driver: one request, then wait (bounded) for done; lat = edges after accept
  task automatic convert(input logic [7:0] v, input bit push, output int lat, output int busy_cnt);
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = v;
    if (push) exp_q.push_back(ref_bcd(int'(v)));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.bin   = 8'($urandom_range(0, 255));
    lat = -1;
    busy_cnt = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        lat = i - 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.bin = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, digits()} !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs got=%h expected=0", {bus.busy, bus.done, digits()});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, digits()} !== 14'h0 || bus.state_dbg !== ST_IDLE) begin
        errors++;
        $display("FAIL idle_cycle%0d got=%h state=%0d expected=0 state=0", i,
                 {bus.busy, bus.done, digits()}, bus.state_dbg);
      end
    end
  endtask

  task automatic test_max();
    int lat, bc;
    convert(8'd255, 1'b1, lat, bc);
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL max_latency got=%0d expected=9", lat);
    end
    checks++;
    if (bc !== 8) begin
      errors++;
      $display("FAIL max_busy_cycles got=%0d expected=8", bc);
    end
    checks++;
    if (digits() !== 12'h255) begin
      errors++;
      $display("FAIL max_digits got=%03h expected=255", digits());
    end
  endtask

  task automatic test_sweep();
    int lat, bc;
    for (int v = 0; v < 256; v++) begin
      convert(8'(v), 1'b1, lat, bc);
      checks++;
      if (lat !== 9) begin
        errors++;
        $display("FAIL sweep_latency bin=%0d got=%0d expected=9", v, lat);
      end
      if (v == 0 || v == 14 || v == 100) begin
        logic [11:0] want;
        want = (v == 0) ? 12'h000 : (v == 14) ? 12'h014 : 12'h100;
        checks++;
        if (digits() !== want) begin
          errors++;
          $display("FAIL sweep_corner bin=%0d got=%03h expected=%03h", v, digits(), want);
        end
      end
    end
  endtask

  task automatic test_ignore_busy();
    int base, ndone;
    base = done_seen;
    ndone = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin = 8'd123;
    exp_q.push_back(ref_bcd(123));
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.bin = 8'd45;
    @(negedge clk);
    bus.start = 1'b0;
    bus.bin = 8'd0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL ignore_done_count got=%0d expected=1", ndone);
    end
    checks++;
    if (digits() !== 12'h123) begin
      errors++;
      $display("FAIL ignore_digits got=%03h expected=123", digits());
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    bit stable;
    d1 = 0;
    d2 = 0;
    stable = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin = 8'd9;
    exp_q.push_back(ref_bcd(9));
    @(posedge clk);
    #1;
    bus.bin = 8'd200;
    exp_q.push_back(ref_bcd(200));
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.done) begin
        if (d1 == 0) d1 = i;
        else if (d2 == 0) d2 = i;
      end
      if (d1 != 0 && i == d1 + 1) bus.start = 1'b0;
      if (d1 != 0 && d2 == 0 && digits() !== 12'h009) stable = 1'b0;
      if (d2 != 0) break;
    end
    checks++;
    if (d1 == 0 || d2 == 0 || d2 - d1 != 10) begin
      errors++;
      $display("FAIL b2b_spacing got=%0d expected=10 (d1=%0d d2=%0d)", d2 - d1, d1, d2);
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL b2b_hold got=changed expected=009 held between pulses");
    end
    checks++;
    if (digits() !== 12'h200) begin
      errors++;
      $display("FAIL b2b_second got=%03h expected=200", digits());
    end
  endtask

  task automatic test_reset_mid();
    int base, lat, bc;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin = 8'd77;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, digits()} !== 14'h0 || bus.state_dbg !== ST_IDLE) begin
      errors++;
      $display("FAIL mid_reset got=%h state=%0d expected=0 state=0",
               {bus.busy, bus.done, digits()}, bus.state_dbg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    base = done_seen;
    repeat (15) @(negedge clk);
    checks++;
    if (done_seen !== base || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_quiet got=%0d dones busy=%b expected=0 dones busy=0",
               done_seen - base, bus.busy);
    end
    convert(8'd77, 1'b1, lat, bc);
    checks++;
    if (lat !== 9 || digits() !== 12'h077) begin
      errors++;
      $display("FAIL after_reset_conv got=%03h lat=%0d expected=077 lat=9", digits(), lat);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.bin = '0;
    rst_n = 1'b0;
    test_reset();
    test_max();
    test_sweep();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_seq_bin2bcd

// File: doc/seq_bin2bcd.md
Name: seq_bin2bcd

Overview:
Iterative (double-dabble) binary-to-BCD converter.
- Sits between the ripple adder result bus and the per-digit hex_7seg decoders; it is the sequential replacement for the combinational add-3 array.
- Captures a WIDTH-bit binary value on a start pulse and shifts one bit per clock.
- Presents registered ONES/TENS/HUNDREDS digits with a one-cycle done pulse.
- Previous result is held stable on the outputs until the next conversion completes.

Parameters:
WIDTH, 8, binary input width in bits (1..8 supported; 3 digits cover 0..255)
DIGITS, 3, number of BCD digits computed internally (fixed 3 for this block; outputs are the low three)

Ports:
CLOCK_50  input  1  system clock, 50 MHz, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request conversion; sampled only in IDLE
bin  input  WIDTH  binary value; captured on the accepted start cycle only
busy  output  1  high while a conversion is in progress (SHIFT state)
done  output  1  one-cycle pulse when new digits are valid on the outputs
ONES  output  4  BCD units digit, registered
TENS  output  4  BCD tens digit, registered
HUNDREDS  output  4  BCD hundreds digit, registered (upper 2 bits always 0 for WIDTH=8)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, ONES=TENS=HUNDREDS=4'h0; internal shift register, scratch digits and bit counter cleared. Release is synchronous to CLOCK_50 by the system; no extra sync inside.
- States:
  - IDLE: busy=0. On start=1, load shift reg <= bin, scratch digits <= 0, count <= WIDTH, go SHIFT.
  - SHIFT: busy=1. Each cycle:
    - every scratch digit >=5 gets +3 (via dabble_digit);
    - the corrected {digits, shift reg} is shifted left one bit; MSB of the shift reg enters units bit 0;
    - count decrements.
    - When count reaches 1 on this cycle (last bit consumed), go DONE.
  - DONE: copy scratch digits to ONES/TENS/HUNDREDS, assert done for this single cycle, go IDLE.
- Latency: start accepted at edge N -> busy high cycles N+1..N+WIDTH -> outputs update and done=1 at edge N+WIDTH+1 (9 cycles for WIDTH=8). Throughput: one conversion per WIDTH+2 cycles.
- start while busy or in DONE: ignored, no queuing; bin changes during SHIFT have no effect.
- start held high continuously: new conversion accepted on the first IDLE cycle after each DONE (back-to-back, period WIDTH+2).
- Outputs change only in DONE; between conversions they hold the last result.
- Reset mid-conversion: immediate abort, all outputs 0, no done pulse.
- Arithmetic: +3 correction applied before shift, per digit, 4-bit, no carry between digits (never overflows since digit <=9 before correction). Max input 255 -> 2/5/5.
- done and busy are never high in the same cycle.

Decomposition:
- Shared package: state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2; BCD_W=4; default WIDTH=8.
- One sub-module: dabble_digit (4-bit in, 4-bit out; in>=5 ? in+3 : in), instantiated DIGITS times. Inputs 10..15 are unreachable and map to 4'h0.
- Top-level integration (not this block): start driven from adder-result-change detect or KEY press; ONES/TENS/HUNDREDS feed hex_7seg dsp0/1/2.

Test Plan:
- Reset then idle 20 cycles -> busy=0, done=0, ONES=TENS=HUNDREDS=0.
- start=1 for 1 cycle with bin=8'd255 -> done pulse exactly 9 cycles later; HUNDREDS=2, TENS=5, ONES=5; busy high for exactly 8 cycles.
- Sweep bin=0..255, one conversion each -> digits equal bin/100, (bin/10)%10, bin%10; bin=0 -> 0/0/0; bin=100 -> 1/0/0; bin=14 (3-bit adder max 7+7) -> 0/1/4.
- Convert bin=8'd123, then pulse start with bin=8'd45 while busy -> ignored; result 1/2/3; no second done pulse.
- start held high, bin=8'd9 then 8'd200 -> done pulses 10 cycles apart; outputs 0/0/9 then 2/0/0; outputs stable between pulses.
- Start bin=8'd77, assert rst_n=0 at cycle 4 -> outputs immediately 0, busy=0; after release, no done until a new start.
